// File: rtl/demux1_to_2_buf.sv
// demux1_to_2_buf
//   Registered 1-to-2 data router. A single producer presents a word plus a
//   select bit. The word is steered into one of two independent 2-entry
//   output queues. Each queue has its own valid/ready consumer.
//
//   Ports:
//     clk, rst_n             clock, async active-low reset
//     in_data/in_sel         word and destination (0 -> out0, 1 -> out1)
//     in_valid/in_ready      producer handshake; in_ready depends only on
//                            in_sel and the registered counts
//     outN_data/outN_valid   head of queue N, queue N non-empty
//     outN_ready             consumer N takes the head
//     count0/count1          queue occupancy, 0..2
//
//   demux1_to_2_buf_q is one per-queue lane, instantiated in a generate array.

module demux1_to_2_buf_q #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;
  logic [1:0]            cnt_q, cnt_d;

  // The parent only pushes when the queue is not full and only pops when it
  // is non-empty, so the count cannot leave 0..2 here.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Head comes straight from storage: no path from push_data to head.
  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;
endmodule

module demux1_to_2_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2   // fixed queue depth; pointers are 1 bit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [1:0]       count0,
  output logic [1:0]       count1
);
  localparam int          NQ   = 2;
  localparam logic [1:0]  FULL = 2'(DEPTH);

  logic [NQ-1:0][WIDTH-1:0] head;
  logic [NQ-1:0][1:0]       cnt;
  logic [NQ-1:0]            push, pop, o_valid, o_ready;
  logic                     acc;

  assign o_ready = {out1_ready, out0_ready};

  // Full check uses registered counts only, so a full queue does not accept
  // even when its consumer pops in the same cycle.
  assign in_ready = (in_sel ? cnt[1] : cnt[0]) != FULL;
  assign acc      = in_valid & in_ready;

  always_comb begin
    push    = '0;
    push[0] = acc & ~in_sel;
    push[1] = acc &  in_sel;
  end

  for (genvar i = 0; i < NQ; i++) begin : g_q
    assign o_valid[i] = cnt[i] != 2'd0;
    assign pop[i]     = o_valid[i] & o_ready[i];

    demux1_to_2_buf_q #(.WIDTH(WIDTH)) u_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (pop[i]),
      .head      (head[i]),
      .cnt       (cnt[i])
    );
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_valid = o_valid[0];
  assign out1_valid = o_valid[1];
  assign count0     = cnt[0];
  assign count1     = cnt[1];
endmodule

// File: tb/tb_demux1_to_2_buf.sv
module tb_demux1_to_2_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [15:0] out0_data, out1_data;
  logic        out0_valid, out1_valid, out0_ready, out1_ready;
  logic [1:0]  count0, count1;

  demux1_to_2_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference queues: pushed on accept, popped and compared on DUT pop.
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    bit          v;
    bit          sel;
    logic [15:0] d;
    bit          r0;
    bit          r1;
    bit          exp_rdy;
    int          exp_c0;
    int          exp_c1;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle (called just after a negedge), check against the model,
  // advance the model for the coming edge, then wait for the next negedge.
  task automatic step(input bit v, input bit sel, input logic [15:0] d,
                      input bit r0, input bit r1);
    bit          m_rdy;
    logic [15:0] e;
    in_valid = v; in_sel = sel; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    m_rdy = sel ? (q1.size() != 2) : (q0.size() != 2);
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("count0", {30'd0, count0}, q0.size());
    chk("count1", {30'd0, count1}, q1.size());
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    if (q0.size() != 0 && r0) begin
      e = q0.pop_front();
      chk("out0_data", {16'd0, out0_data}, {16'd0, e});
    end
    if (q1.size() != 0 && r1) begin
      e = q1.pop_front();
      chk("out1_data", {16'd0, out1_data}, {16'd0, e});
    end
    if (v && m_rdy) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input bit v, input bit sel, input logic [15:0] d,
                         input bit r0, input bit r1, input bit rdy, input int c0, input int c1);
    tbl[i].v = v; tbl[i].sel = sel; tbl[i].d = d; tbl[i].r0 = r0; tbl[i].r1 = r1;
    tbl[i].exp_rdy = rdy; tbl[i].exp_c0 = c0; tbl[i].exp_c1 = c1;
  endtask

  initial begin
    // Basic routing
    set_vec(0,  1,0,16'h1234, 1,1, 1,0,0);
    set_vec(1,  1,1,16'hABCD, 1,1, 1,1,0);
    set_vec(2,  0,0,16'h0000, 1,1, 1,0,1);
    set_vec(3,  0,0,16'h0000, 1,1, 1,0,0);
    // Fill and stall queue 0
    set_vec(4,  1,0,16'h0001, 0,1, 1,0,0);
    set_vec(5,  1,0,16'h0002, 0,1, 1,1,0);
    set_vec(6,  1,0,16'h0003, 0,1, 0,2,0);
    set_vec(7,  1,0,16'h0003, 0,1, 0,2,0);
    // Cross-queue independence while queue 0 is full
    set_vec(8,  1,1,16'h5555, 0,0, 1,2,0);
    set_vec(9,  0,0,16'h0000, 0,0, 0,2,1);
    set_vec(10, 0,1,16'h0000, 0,1, 1,2,1);
    // Release queue 0; 0x0003 goes in the cycle after the first pop
    set_vec(11, 1,0,16'h0003, 1,1, 0,2,0);
    set_vec(12, 1,0,16'h0003, 1,1, 1,1,0);
    set_vec(13, 0,0,16'h0000, 1,1, 1,1,0);
    set_vec(14, 0,0,16'h0000, 1,1, 1,0,0);
    // Simultaneous push/pop at count 1
    set_vec(15, 1,0,16'h00AA, 0,1, 1,0,0);
    set_vec(16, 1,0,16'h00BB, 1,1, 1,1,0);
    set_vec(17, 0,0,16'h0000, 0,1, 1,1,0);
    set_vec(18, 0,0,16'h0000, 1,1, 1,1,0);
    set_vec(19, 0,0,16'h0000, 1,1, 1,0,0);

    rst_n = 1'b0; in_valid = 0; in_sel = 0; in_data = '0;
    out0_ready = 0; out1_ready = 0;
    #1;
    chk("rst_count0", {30'd0, count0}, 0);
    chk("rst_count1", {30'd0, count1}, 0);
    chk("rst_valid", {30'd0, out1_valid, out0_valid}, 0);
    chk("rst_data", {out1_data, out0_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d;
      out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("vec%0d_count0", i), {30'd0, count0}, tbl[i].exp_c0);
      chk($sformatf("vec%0d_count1", i), {30'd0, count1}, tbl[i].exp_c1);
      if (i == 17) chk("vec17_out0_data", {16'd0, out0_data}, 32'h00BB);
      if (i == 9)  chk("vec9_out1_data", {16'd0, out1_data}, 32'h5555);
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
    end

    // Reset mid-run with both queues full
    step(1, 0, 16'h1111, 0, 0);
    step(1, 0, 16'h2222, 0, 0);
    step(1, 1, 16'h3333, 0, 0);
    step(1, 1, 16'h4444, 0, 0);
    chk("pre_rst_full", {28'd0, count1, count0}, 32'hA);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_count0", {30'd0, count0}, 0);
    chk("midrst_count1", {30'd0, count1}, 0);
    chk("midrst_valid", {30'd0, out1_valid, out0_valid}, 0);
    chk("midrst_data", {out1_data, out0_data}, 0);
    q0.delete(); q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);

    // Streaming 1000 words into queue 0 with consumer always ready
    for (int i = 0; i < 1000; i++) step(1, 0, 16'(i + 16'h8000), 1, 1);
    step(0, 0, 16'h0, 1, 1);
    step(0, 0, 16'h0, 1, 1);
    chk("stream_drained", q0.size(), 0);

    // Random traffic; producer holds the word while stalled
    begin
      logic [15:0] rd;
      bit          rs, rv;
      rd = 16'($urandom); rs = 1'($urandom); rv = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        bit will_acc;
        if (!rv || $urandom_range(0, 7) == 0) begin
          rv = 1'($urandom);
          rs = 1'($urandom);
          rd = 16'($urandom);
        end
        will_acc = rv && (rs ? q1.size() != 2 : q0.size() != 2);
        step(rv, rs, rd, 1'($urandom), 1'($urandom));
        if (will_acc) rv = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux1_to_2_buf.md
# demux1_to_2_buf

Registered 1-to-2 data router for the 16-bit RISC datapath; it is the steering counterpart of the 2-to-1 operand/result selector. A single producer, such as an ALU or load result stream, presents a word with a select bit. The block steers the word into one of two independent 2-entry output queues, e.g. register-file write port (0) and store/IO port (1). Valid/ready handshakes on all three sides let either consumer stall without losing data.

## Interface
- WIDTH, 16, data word width
- DEPTH, 2, entries per output queue (fixed; not to be overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  word to route
- in_sel  in  1  destination: 0 → out0, 1 → out1
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- out0_data  out  WIDTH  head of queue 0
- out0_valid  out  1  queue 0 non-empty
- out0_ready  in  1  consumer 0 takes head
- out1_data  out  WIDTH  head of queue 1
- out1_valid  out  1  queue 1 non-empty
- out1_ready  in  1  consumer 1 takes head
- count0  out  2  occupancy of queue 0 (0..2)
- count1  out  2  occupancy of queue 1 (0..2)

## Operation
- Reset is asynchronous and active-low: while rst_n=0, count0=count1=0, out0_valid=out1_valid=0, out0_data=out1_data=0, and both queue pointers are 0. in_ready follows from the counts, so it is 1 during and after reset.
- in_ready = (in_sel ? count1 : count0) != 2. It is combinational from in_sel and registered counts only. It does not depend on out*_ready, so there is no pop-through on a full queue.
- Push: on a rising edge with in_valid & in_ready, in_data is written to the queue selected by in_sel at its write pointer. The write pointer toggles and the count increments.
- Pop: on a rising edge with outN_valid & outN_ready, the read pointer of queue N toggles and countN decrements.
- Simultaneous push and pop on the same queue: the count is unchanged and both pointers toggle. This is legal at count 1 and at count 0→ not applicable, since a pop requires valid.
- Push to one queue while popping the other: the events are independent.
- outN_valid = (countN != 0). outN_data is the queue entry at the read pointer, driven from storage registers with no combinational path from in_data.
- Order is preserved per queue. Words routed to different queues carry no relative ordering guarantee.
- in_ready=0 with in_valid=1: the word is not taken. The producer must hold in_data/in_sel stable until accepted. in_sel changing while stalled is allowed, and in_ready re-evaluates accordingly.
- outN_ready asserted while outN_valid=0 has no effect. The count never underflows and never exceeds 2.
- Pointers are 1-bit and wrap 1→0 naturally.
- Reset mid-operation: all queued words are discarded at once. Stored data values become 0 and do not need to be preserved.

## Timing
- Latency: a word accepted at edge N is visible on outN_data/outN_valid immediately after edge N (1-cycle registered). A consumer can take it at edge N+1.
- Throughput: 1 word/cycle per queue in steady state when the consumer is ready every cycle (count oscillates 0↔1 or holds at 1).
- A full queue (count 2) regains in_ready in the cycle after the pop edge.
- No combinational path from outN_ready to in_ready, or from in_data to outN_data.

## Test plan
- Reset: assert rst_n=0 mid-run with both queues full → the same cycle gives out0_valid=out1_valid=0 and count0=count1=0; after release in_ready=1.
- Basic routing: push 0x1234 sel=0, then 0xABCD sel=1, both consumers ready → out0_data=0x1234 one cycle after the first accept, out1_data=0xABCD one cycle after the second; each valid for exactly 1 cycle.
- Fill and stall: out0_ready=0, push 0x0001, 0x0002, 0x0003 to sel=0 → first two accepted, count0=2, in_ready=0 holding 0x0003. Release out0_ready → pops 0x0001, 0x0002, 0x0003 in order; 0x0003 is accepted the cycle after the first pop.
- Cross-queue independence: queue 0 full and stalled; push 0x5555 sel=1 → accepted immediately (in_ready=1 when in_sel=1, 0 when in_sel=0); out1_data=0x5555.
- Simultaneous push/pop at count 1: queue 0 holding 0x00AA, push 0x00BB sel=0 and pop in the same cycle → count0 stays 1 and out0_data becomes 0x00BB; 1000-cycle streaming run loses and duplicates no words.
- Random: random in_valid/in_sel/outN_ready for 10k cycles against a scoreboard of two reference FIFOs → exact per-queue order match, counts always in 0..2, no accept when the target queue is full.
